mux_scan_ctrl: RTL and testbench

- Sequencer directly upstream of the 4:1 select mux.
- Drives the mux select lines sa/sb through the enabled channels in turn, waits a settle time, then samples the muxed output y back into a per-channel register.
- Turns the combinational mux into a scanned 4-input sampler; downstream logic reads the sample vector and acts on the done pulse.

---
 rtl/mux_scan_ctrl_pkg.sv | 20 ++
 rtl/mux_scan_next_idx.sv | 26 ++
 rtl/mux_scan_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux scan sequencer: FSM state encodings,
// channel index constants and the channel count.
package mux_scan_ctrl_pkg;

  localparam int NUM_CH = 4;

  // Channel indices as driven onto {sa,sb}
  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } scan_state_t;

endpackage

// File: rtl/mux_scan_next_idx.sv
// Combinational priority finder for the scan sequencer. With from_start set
// it returns the lowest set bit of en; otherwise the lowest set bit strictly
// above cur_idx. found is low when no qualifying bit exists.
module mux_scan_next_idx
  import mux_scan_ctrl_pkg::*;
(
  input  logic [NUM_CH-1:0] en,
  input  logic [1:0]        cur_idx,
  input  logic              from_start,
  output logic [1:0]        nxt_idx,
  output logic              found
);

  // Walk from the top down so the lowest qualifying bit is the last written
  always_comb begin
    nxt_idx = CH_A;
    found   = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (en[i] && (from_start || (i > int'(cur_idx)))) begin
        nxt_idx = 2'(i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer sitting in front of a 4:1 select mux. Steps {sa,sb} through
// the enabled channels, holds each select for DWELL cycles, then captures the
// fed-back mux output y_in into samples[idx]. Pulses done at the end of each
// scan and optionally rescans when continuous is high.
//
// Optional build macro MUX_SCAN_CHG_EN adds per-channel change flags (chg)
// and a change interrupt (chg_irq) that pulses together with done.
//
// DWELL must be in 1..15 and fit in CNT_W bits.
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int DWELL = 2,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUM_CH-1:0] chan_en,
  input  logic              continuous,
  input  logic              y_in,
  output logic              sa,
  output logic              sb,
  output logic [NUM_CH-1:0] samples,
  output logic [NUM_CH-1:0] valid,
  output logic              busy,
`ifdef MUX_SCAN_CHG_EN
  output logic [NUM_CH-1:0] chg,
  output logic              chg_irq,
`endif
  output logic              done
);

  scan_state_t       state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] samples_d;
  logic [NUM_CH-1:0] valid_d;
  logic              busy_d;
  logic              done_d;
`ifdef MUX_SCAN_CHG_EN
  logic [NUM_CH-1:0] chg_d;
  logic              chg_irq_d;
`endif

  // Finder inputs: during SAMPLE look above the current channel in the
  // latched mask; otherwise (scan start/restart) search the live mask.
  logic [NUM_CH-1:0] find_en;
  logic              find_from_start;
  logic [1:0]        find_idx;
  logic              find_found;

  assign find_en         = (state_q == SAMPLE) ? en_q : chan_en;
  assign find_from_start = (state_q != SAMPLE);

  mux_scan_next_idx u_next_idx (
    .en         (find_en),
    .cur_idx    (idx_q),
    .from_start (find_from_start),
    .nxt_idx    (find_idx),
    .found      (find_found)
  );

  // The select register doubles as the channel index
  assign sa = idx_q[1];
  assign sb = idx_q[0];

  // Next-state and next-output logic; every register output is decoded from
  // the next state so the ports stay registered.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    en_d      = en_q;
    cnt_d     = cnt_q;
    samples_d = samples;
    valid_d   = valid;
`ifdef MUX_SCAN_CHG_EN
    chg_d     = chg;
`endif
    unique case (state_q)
      IDLE: begin
        // A start with an empty mask is dropped silently
        if (start && (chan_en != '0)) begin
          en_d    = chan_en;
          valid_d = '0;
`ifdef MUX_SCAN_CHG_EN
          chg_d   = '0;
`endif
          idx_d   = find_idx;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(DWELL - 1)) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SAMPLE: begin
        samples_d[idx_q] = y_in;
        valid_d[idx_q]   = 1'b1;
`ifdef MUX_SCAN_CHG_EN
        chg_d[idx_q]     = (y_in != samples[idx_q]);
`endif
        if (find_found) begin
          idx_d   = find_idx;
          cnt_d   = '0;
          state_d = SETTLE;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Back-to-back rescan re-latches the live mask
        if (continuous && (chan_en != '0)) begin
          en_d    = chan_en;
          valid_d = '0;
`ifdef MUX_SCAN_CHG_EN
          chg_d   = '0;
`endif
          idx_d   = find_idx;
          cnt_d   = '0;
          state_d = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
    done_d = (state_d == DONE);
`ifdef MUX_SCAN_CHG_EN
    // chg_d already includes the bit written by the final SAMPLE
    chg_irq_d = (state_d == DONE) && (chg_d != '0);
`endif
  end

  // State and output registers; reset aborts any scan without a done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= CH_A;
      en_q    <= '0;
      cnt_q   <= '0;
      samples <= '0;
      valid   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef MUX_SCAN_CHG_EN
      chg     <= '0;
      chg_irq <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      samples <= samples_d;
      valid   <= valid_d;
      busy    <= busy_d;
      done    <= done_d;
`ifdef MUX_SCAN_CHG_EN
      chg     <= chg_d;
      chg_irq <= chg_irq_d;
`endif
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl (DWELL=2). y_in is modelled as a mux
// driven by the DUT select lines over a bench-owned 4-bit input pattern.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] chan_en;
  logic       continuous;
  logic       y_in;
  logic       sa;
  logic       sb;
  logic [3:0] samples;
  logic [3:0] valid;
  logic       busy;
  logic       done;
`ifdef MUX_SCAN_CHG_EN
  logic [3:0] chg;
  logic       chg_irq;
`endif

  logic [3:0] ymap;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] sel_seq;
  int         n_sel;
  logic [1:0] last_sel;
  int         n;
  int         nd;
  int         nb;

  always #5 clk = ~clk;

  assign y_in = ymap[{sa, sb}];

  mux_scan_ctrl #(.DWELL(2), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .chan_en    (chan_en),
    .continuous (continuous),
    .y_in       (y_in),
    .sa         (sa),
    .sb         (sb),
    .samples    (samples),
    .valid      (valid),
    .busy       (busy),
`ifdef MUX_SCAN_CHG_EN
    .chg        (chg),
    .chg_irq    (chg_irq),
`endif
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock, then settle past the edge; log select changes while busy
  task automatic tick();
    @(posedge clk);
    #1;
    if (busy && ((n_sel == 0) || (last_sel != {sa, sb}))) begin
      sel_seq  = {sel_seq[5:0], sa, sb};
      last_sel = {sa, sb};
      n_sel++;
    end
  endtask

  task automatic clr_log();
    sel_seq = '0;
    n_sel   = 0;
  endtask

  task automatic wait_done(input int max, output int cnt);
    cnt = 0;
    for (int i = 0; i < max; i++) begin
      tick();
      cnt++;
      if (done) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; chan_en = 4'b0000; continuous = 1'b0; ymap = 4'b0000;
    clr_log();
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sel", {sa, sb}, 0);
    chk("rst_samples", samples, 0);
    chk("rst_valid", valid, 0);
    rst = 1'b0;
    tick();

    // Full scan of all four channels
    ymap = 4'b0101; chan_en = 4'b1111; clr_log();
    start = 1'b1; tick(); start = 1'b0;
    chk("full_busy", busy, 1);
    wait_done(30, n);
    chk("full_latency", n + 1, 13);
    chk("full_samples", samples, 4'b0101);
    chk("full_valid", valid, 4'b1111);
    chk("full_selseq", sel_seq, 8'h1B);
    chk("full_nsel", n_sel, 4);
    tick();
    chk("full_done_pulse", done, 0);
    chk("full_idle_busy", busy, 0);

    // Reset during the second channel's SETTLE
    clr_log();
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    chk("abort_pre_sel", {sa, sb}, 2'b01);
    chk("abort_pre_busy", busy, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_sel", {sa, sb}, 0);
    chk("abort_samples", samples, 0);
    chk("abort_valid", valid, 0);
    chk("abort_done", done, 0);
    nd = 0;
    repeat (20) begin tick(); if (done) nd++; end
    chk("abort_no_done", nd, 0);

    // Known sample state before the sparse scan
    ymap = 4'b0001; chan_en = 4'b1111;
    start = 1'b1; tick(); start = 1'b0;
    wait_done(30, n);
    chk("prep_latency", n + 1, 13);
    chk("prep_samples", samples, 4'b0001);
    tick();

    // Sparse mask: only b and d scanned, a and c keep old samples
    ymap = 4'b1010; chan_en = 4'b1010; clr_log();
    start = 1'b1; tick(); start = 1'b0;
    wait_done(30, n);
    chk("sparse_latency", n + 1, 7);
    chk("sparse_valid", valid, 4'b1010);
    chk("sparse_samples", samples, 4'b1011);
    chk("sparse_selseq", sel_seq[3:0], 4'b0111);
    chk("sparse_nsel", n_sel, 2);
    tick();

    // Start with an empty mask is ignored; select holds
    chan_en = 4'b0000; start = 1'b1;
    nd = 0; nb = 0;
    repeat (5) begin tick(); if (done) nd++; if (busy) nb++; end
    start = 1'b0;
    chk("zero_no_done", nd, 0);
    chk("zero_no_busy", nb, 0);
    chk("zero_sel_hold", {sa, sb}, 2'b11);

    // Start re-pulsed in SETTLE and mask change mid-scan are both ignored
    chan_en = 4'b0001; start = 1'b1; tick(); start = 1'b0;
    chan_en = 4'b1111; tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_done(30, n);
    chk("midstart_latency", n + 3, 4);
    chk("midstart_valid", valid, 4'b0001);
    tick();
    chk("midstart_idle", busy, 0);
    chk("midstart_done_low", done, 0);

    // Continuous rescans every 4 cycles until continuous drops
    chan_en = 4'b0001; continuous = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    wait_done(30, n);
    chk("cont_first", n + 1, 4);
    wait_done(30, n);
    chk("cont_period", n, 4);
    tick();
    chk("cont_rescan_busy", busy, 1);
    continuous = 1'b0;
    wait_done(30, n);
    chk("cont_last", n + 1, 4);
    tick();
    chk("cont_stop_busy", busy, 0);
    nd = 0;
    repeat (8) begin tick(); if (done) nd++; end
    chk("cont_stop_no_done", nd, 0);
    chk("cont_samples", samples, 4'b1010);

`ifdef MUX_SCAN_CHG_EN
    chan_en = 4'b1111;
    ymap = 4'b0101;
    start = 1'b1; tick(); start = 1'b0;
    wait_done(30, n);
    chk("chgA_latency", n + 1, 13);
    chk("chgA_chg", chg, 4'b1111);
    chk("chgA_irq", chg_irq, 1);
    tick();
    ymap = 4'b0001;
    start = 1'b1; tick(); start = 1'b0;
    wait_done(30, n);
    chk("chgB_chg", chg, 4'b0100);
    chk("chgB_irq", chg_irq, 1);
    tick();
    chk("chgB_irq_pulse", chg_irq, 0);
    start = 1'b1; tick(); start = 1'b0;
    wait_done(30, n);
    chk("chgC_chg", chg, 4'b0000);
    chk("chgC_irq", chg_irq, 0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
